// File: rtl/stopwatch_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stopwatch_counter                                              |
// | Brief    : MM:SS BCD up-counter (00:00-59:59) advanced by step edges;     |
// |            optional lap hold via macro STOPWATCH_LAP_HOLD_EN.             |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module stopwatch_counter #(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       step,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       carry,
  output logic       full,
  output logic       lap_active
);

  logic       r_step_q;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic       r_carry;
  logic       w_tick;
  logic       w_at_max;

  assign w_tick   = step & ~r_step_q;
  assign w_at_max = (r_min_tens == 4'd5) && (r_min_ones == 4'd9) &&
                    (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);

  // Edge register runs regardless of enable, so edges seen while stopped are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_carry    <= 1'b0;
    end else if (clear) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_carry    <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (w_tick && enable) begin
        if (w_at_max) begin
          if (WRAP) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_carry    <= 1'b1;
          end
        end else if (r_sec_ones != 4'd9) begin
          r_sec_ones <= r_sec_ones + 4'd1;
        end else begin
          r_sec_ones <= 4'd0;
          if (r_sec_tens != 4'd5) begin
            r_sec_tens <= r_sec_tens + 4'd1;
          end else begin
            r_sec_tens <= 4'd0;
            if (r_min_ones != 4'd9) begin
              r_min_ones <= r_min_ones + 4'd1;
            end else begin
              // min_tens < 5 here: the 59:59 case is handled above
              r_min_ones <= 4'd0;
              r_min_tens <= r_min_tens + 4'd1;
            end
          end
        end
      end
    end
  end

  assign carry = r_carry;
  assign full  = w_at_max;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       r_lap_q;
  logic       r_hold;
  logic [3:0] r_disp_sec_ones;
  logic [3:0] r_disp_sec_tens;
  logic [3:0] r_disp_min_ones;
  logic [3:0] r_disp_min_tens;
  logic       w_lap_edge;

  assign w_lap_edge = lap & ~r_lap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap_q         <= 1'b0;
      r_hold          <= 1'b0;
      r_disp_sec_ones <= 4'd0;
      r_disp_sec_tens <= 4'd0;
      r_disp_min_ones <= 4'd0;
      r_disp_min_tens <= 4'd0;
    end else begin
      r_lap_q <= lap;
      if (clear) begin
        r_hold          <= 1'b0;
        r_disp_sec_ones <= 4'd0;
        r_disp_sec_tens <= 4'd0;
        r_disp_min_ones <= 4'd0;
        r_disp_min_tens <= 4'd0;
      end else if (w_lap_edge) begin
        r_hold <= ~r_hold;
        if (!r_hold) begin
          r_disp_sec_ones <= r_sec_ones;
          r_disp_sec_tens <= r_sec_tens;
          r_disp_min_ones <= r_min_ones;
          r_disp_min_tens <= r_min_tens;
        end
      end
    end
  end

  assign sec_ones   = r_hold ? r_disp_sec_ones : r_sec_ones;
  assign sec_tens   = r_hold ? r_disp_sec_tens : r_sec_tens;
  assign min_ones   = r_hold ? r_disp_min_ones : r_min_ones;
  assign min_tens   = r_hold ? r_disp_min_tens : r_min_tens;
  assign lap_active = r_hold;
`else
  logic w_unused_lap;

  assign w_unused_lap = lap;
  assign sec_ones     = r_sec_ones;
  assign sec_tens     = r_sec_tens;
  assign min_ones     = r_min_ones;
  assign min_tens     = r_min_tens;
  assign lap_active   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// Testbench for stopwatch_counter: WRAP=0 and WRAP=1 instances share stimulus
// and are checked against a seconds-based reference model.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic reset, enable, step, clear, lap;
  logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
  logic carry0, full0, la0, carry1, full1, la1;

  always #5 clk = ~clk;

  stopwatch_counter #(.WRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .step(step), .clear(clear), .lap(lap),
    .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
    .carry(carry0), .full(full0), .lap_active(la0)
  );

  stopwatch_counter #(.WRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .step(step), .clear(clear), .lap(lap),
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
    .carry(carry1), .full(full1), .lap_active(la1)
  );

  logic [15:0] d_disp [2];
  logic        d_carry [2];
  logic        d_full [2];
  logic        d_lap [2];
  assign d_disp[0]  = {mt0, mo0, st0, so0};
  assign d_disp[1]  = {mt1, mo1, st1, so1};
  assign d_carry[0] = carry0;
  assign d_carry[1] = carry1;
  assign d_full[0]  = full0;
  assign d_full[1]  = full1;
  assign d_lap[0]   = la0;
  assign d_lap[1]   = la1;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int MAX_S = 59 * 60 + 59;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: elapsed seconds per instance, plus lap latch
  int   m_secs [2];
  bit   m_carry [2];
  bit   m_hold [2];
  int   m_lat [2];
  logic m_step_q, m_lap_q;

  function automatic logic [15:0] bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] exp_disp(input int i);
    return bcd(m_hold[i] ? m_lat[i] : m_secs[i]);
  endfunction

  task automatic model_reset();
    m_step_q = 1'b0;
    m_lap_q  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_secs[i] = 0; m_carry[i] = 1'b0; m_hold[i] = 1'b0; m_lat[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic tk, le;
    tk = step & ~m_step_q;
    le = lap & ~m_lap_q;
    m_step_q = step;
    m_lap_q  = lap;
    for (int i = 0; i < 2; i++) begin
      m_carry[i] = 1'b0;
      if (clear) begin
        m_secs[i] = 0; m_hold[i] = 1'b0; m_lat[i] = 0;
      end else begin
        if (LAP_EN && le) begin
          if (!m_hold[i]) begin m_hold[i] = 1'b1; m_lat[i] = m_secs[i]; end
          else m_hold[i] = 1'b0;
        end
        if (tk && enable) begin
          if (m_secs[i] < MAX_S) m_secs[i] = m_secs[i] + 1;
          else if (i == 1) begin m_secs[i] = 0; m_carry[i] = 1'b1; end
        end
      end
    end
  endtask

  task automatic cycle(input logic en, input logic st, input logic clr, input logic lp);
    enable = en; step = st; clear = clr; lap = lp;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic apply_reset();
    enable = 1'b0; step = 1'b0; clear = 1'b0; lap = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b0; step = 1'b0; clear = 1'b0; lap = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h0000) begin n_fail++; $display("FAIL reset_disp dut%0d: got %h expected 0000", i, d_disp[i]); end
      n_cmp++; if (d_carry[i] !== 1'b0) begin n_fail++; $display("FAIL reset_carry dut%0d: got %b expected 0", i, d_carry[i]); end
      n_cmp++; if (d_full[i] !== 1'b0) begin n_fail++; $display("FAIL reset_full dut%0d: got %b expected 0", i, d_full[i]); end
      n_cmp++; if (d_lap[i] !== 1'b0) begin n_fail++; $display("FAIL reset_lap dut%0d: got %b expected 0", i, d_lap[i]); end
    end
    reset = 1'b0;
  endtask

  task automatic test_count10();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (d_carry[i] !== 1'b0) begin n_fail++; $display("FAIL count10_carry dut%0d: got %b expected 0", i, d_carry[i]); end
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h0010) begin n_fail++; $display("FAIL count10_disp dut%0d: got %h expected 0010", i, d_disp[i]); end
    end
  endtask

  task automatic test_carry_chain();
    apply_reset();
    ticks(59);
    n_cmp++; if (d_disp[0] !== 16'h0059) begin n_fail++; $display("FAIL chain_0059: got %h expected 0059", d_disp[0]); end
    tick();
    n_cmp++; if (d_disp[0] !== 16'h0100) begin n_fail++; $display("FAIL chain_0100: got %h expected 0100", d_disp[0]); end
    ticks(539);
    n_cmp++; if (d_disp[1] !== 16'h0959) begin n_fail++; $display("FAIL chain_0959: got %h expected 0959", d_disp[1]); end
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h1000) begin n_fail++; $display("FAIL chain_1000 dut%0d: got %h expected 1000", i, d_disp[i]); end
    end
  endtask

  task automatic test_saturate_wrap();
    ticks(MAX_S - 600);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h5959) begin n_fail++; $display("FAIL sat_reach dut%0d: got %h expected 5959", i, d_disp[i]); end
      n_cmp++; if (d_full[i] !== 1'b1) begin n_fail++; $display("FAIL sat_full dut%0d: got %b expected 1", i, d_full[i]); end
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (d_disp[0] !== 16'h5959) begin n_fail++; $display("FAIL sat_hold: got %h expected 5959", d_disp[0]); end
      n_cmp++; if (d_full[0] !== 1'b1) begin n_fail++; $display("FAIL sat_hold_full: got %b expected 1", d_full[0]); end
      n_cmp++; if (d_carry[0] !== 1'b0) begin n_fail++; $display("FAIL sat_carry: got %b expected 0", d_carry[0]); end
      n_cmp++; if (d_disp[1] !== exp_disp(1)) begin n_fail++; $display("FAIL wrap_disp: got %h expected %h", d_disp[1], exp_disp(1)); end
      n_cmp++; if (d_carry[1] !== m_carry[1]) begin n_fail++; $display("FAIL wrap_carry: got %b expected %b", d_carry[1], m_carry[1]); end
      if (k == 0) begin
        n_cmp++; if (d_disp[1] !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", d_disp[1]); end
        n_cmp++; if (d_carry[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse: got %b expected 1", d_carry[1]); end
        n_cmp++; if (d_full[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_full_drop: got %b expected 0", d_full[1]); end
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (d_carry[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_end: got %b expected 0", d_carry[1]); end
    end
  endtask

  task automatic test_step_held();
    apply_reset();
    ticks(3);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h0004) begin n_fail++; $display("FAIL held_step dut%0d: got %h expected 0004", i, d_disp[i]); end
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h0004) begin n_fail++; $display("FAIL lost_edge dut%0d: got %h expected 0004", i, d_disp[i]); end
    end
  endtask

  task automatic test_clear_tick();
    apply_reset();
    ticks(7);
    n_cmp++; if (d_disp[0] !== 16'h0007) begin n_fail++; $display("FAIL clear_pre: got %h expected 0007", d_disp[0]); end
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h0000) begin n_fail++; $display("FAIL clear_tick dut%0d: got %h expected 0000", i, d_disp[i]); end
      n_cmp++; if (d_carry[i] !== 1'b0) begin n_fail++; $display("FAIL clear_carry dut%0d: got %b expected 0", i, d_carry[i]); end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    ticks(12 * 60 + 34);
    n_cmp++; if (d_disp[1] !== 16'h1234) begin n_fail++; $display("FAIL areset_pre: got %h expected 1234", d_disp[1]); end
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (d_disp[i] !== 16'h0000) begin n_fail++; $display("FAIL areset_disp dut%0d: got %h expected 0000", i, d_disp[i]); end
      n_cmp++; if (d_full[i] !== 1'b0) begin n_fail++; $display("FAIL areset_full dut%0d: got %b expected 0", i, d_full[i]); end
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_lap();
    apply_reset();
    ticks(5);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
`ifdef STOPWATCH_LAP_HOLD_EN
    n_cmp++; if (d_disp[0] !== 16'h0005) begin n_fail++; $display("FAIL lap_held: got %h expected 0005", d_disp[0]); end
    n_cmp++; if (d_lap[0] !== 1'b1) begin n_fail++; $display("FAIL lap_active_on: got %b expected 1", d_lap[0]); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (d_disp[0] !== 16'h0010) begin n_fail++; $display("FAIL lap_release: got %h expected 0010", d_disp[0]); end
    n_cmp++; if (d_lap[0] !== 1'b0) begin n_fail++; $display("FAIL lap_active_off: got %b expected 0", d_lap[0]); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (d_lap[1] !== 1'b0) begin n_fail++; $display("FAIL lap_clear_exit: got %b expected 0", d_lap[1]); end
    n_cmp++; if (d_disp[1] !== 16'h0000) begin n_fail++; $display("FAIL lap_clear_disp: got %h expected 0000", d_disp[1]); end
`else
    n_cmp++; if (d_disp[0] !== 16'h0010) begin n_fail++; $display("FAIL lap_ignored: got %h expected 0010", d_disp[0]); end
    n_cmp++; if (d_lap[0] !== 1'b0) begin n_fail++; $display("FAIL lap_tied: got %b expected 0", d_lap[0]); end
`endif
  endtask

  task automatic random_run(input int n, input bit allow_clear);
    logic en, st, clr, lp;
    for (int k = 0; k < n; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      st  = 1'($urandom_range(0, 1));
      clr = allow_clear && ($urandom_range(0, 63) == 0);
      lp  = ($urandom_range(0, 15) == 0);
      cycle(en, st, clr, lp);
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (d_disp[i] !== exp_disp(i)) begin n_fail++; $display("FAIL rand_disp dut%0d: got %h expected %h", i, d_disp[i], exp_disp(i)); end
        n_cmp++; if (d_carry[i] !== m_carry[i]) begin n_fail++; $display("FAIL rand_carry dut%0d: got %b expected %b", i, d_carry[i], m_carry[i]); end
        n_cmp++; if (d_full[i] !== (m_secs[i] == MAX_S)) begin n_fail++; $display("FAIL rand_full dut%0d: got %b expected %b", i, d_full[i], (m_secs[i] == MAX_S)); end
        n_cmp++; if (d_lap[i] !== m_hold[i]) begin n_fail++; $display("FAIL rand_lap dut%0d: got %b expected %b", i, d_lap[i], m_hold[i]); end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    random_run(1000, 1'b1);
    apply_reset();
    ticks(MAX_S - 4);
    random_run(400, 1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; step = 1'b0; clear = 1'b0; lap = 1'b0;
    test_reset();
    test_count10();
    test_carry_chain();
    test_saturate_wrap();
    test_step_held();
    test_clear_tick();
    test_async_reset();
    test_lap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
